// File: rtl/unidad_control.sv
// unidad_control: multi-cycle fetch/decode/execute controller for the 8-bit micro.
// It sequences FETCH -> DECODE -> (EXEC) -> WRITE / MEM / HALT. It drives the
// register-file write-data selector, the PC, the data-memory handshake and the ALU opcode.
module unidad_control #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter logic [7:0]  RESET_PC    = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] Instruccion,
  input  logic [7:0]  Resultado,
  input  logic        MemRdy,
  output logic [7:0]  PC,
  output logic [2:0]  SEL,
  output logic [2:0]  NUM,
  output logic [7:0]  Direccion,
  output logic [2:0]  AddrX,
  output logic [2:0]  AddrY,
  output logic [2:0]  ALU_OP,
  output logic        RegWr,
  output logic        MemRd,
  output logic        MemWr,
  output logic        Zero,
  output logic        Halted,
  output logic        BusErr,
  output logic        Illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WRITE  = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_LDA   = 4'h2;
  localparam logic [3:0] OP_LDN   = 4'h3;
  localparam logic [3:0] OP_MOV   = 4'h4;
  localparam logic [3:0] OP_ALU   = 4'h5;
  localparam logic [3:0] OP_STORE = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  // Write-data selector code used by the register-writing opcodes in WRITE.
  function automatic logic [2:0] sel_for_op(input logic [3:0] op);
    case (op)
      OP_LDA:  sel_for_op = 3'd1;
      OP_LDN:  sel_for_op = 3'd2;
      OP_MOV:  sel_for_op = 3'd3;
      OP_ALU:  sel_for_op = 3'd4;
      default: sel_for_op = 3'd0;
    endcase
  endfunction

  state_t      state_r, state_s;
  logic [7:0]  pc_r, pc_s;
  logic [15:0] ir_r, ir_s;
  logic [7:0]  wait_cnt_r, wait_cnt_s;
  logic        zero_r, zero_s;
  logic        buserr_r, buserr_s;
  logic        illegal_r, illegal_s;
  logic        regwr_wr_r, memrd_r, memwr_r, halted_r;
  logic [2:0]  sel_r, alu_op_r;
  logic [3:0]  opcode_s;

  assign opcode_s  = ir_r[15:12];
  assign NUM       = ir_r[2:0];
  assign Direccion = ir_r[7:0];
  assign AddrX     = ir_r[11:9];
  assign AddrY     = ir_r[5:3];

  assign PC      = pc_r;
  assign Zero    = zero_r;
  assign BusErr  = buserr_r;
  assign Illegal = illegal_r;
  assign Halted  = halted_r;
  assign SEL     = sel_r;
  assign ALU_OP  = alu_op_r;
  assign MemRd   = memrd_r;
  assign MemWr   = memwr_r;
  // A LOAD writes the register file in the very cycle the memory acknowledges.
  assign RegWr   = regwr_wr_r | (memrd_r & MemRdy);

  // Next-state and datapath-register update rules for every controller state.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    ir_s       = ir_r;
    wait_cnt_s = wait_cnt_r;
    zero_s     = zero_r;
    buserr_s   = buserr_r;
    illegal_s  = illegal_r;
    case (state_r)
      S_FETCH: begin
        ir_s    = Instruccion;
        pc_s    = pc_r + 8'd1;
        state_s = S_DECODE;
      end
      S_DECODE: begin
        case (opcode_s)
          OP_NOP:                   state_s = S_FETCH;
          OP_LDA, OP_LDN, OP_MOV:   state_s = S_WRITE;
          OP_ALU:                   state_s = S_EXEC;
          OP_LOAD, OP_STORE: begin
            wait_cnt_s = 8'd0;
            state_s    = S_MEM;
          end
          OP_JMP: begin
            pc_s    = ir_r[7:0];
            state_s = S_FETCH;
          end
          OP_JZ: begin
            if (zero_r) begin
              pc_s = ir_r[7:0];
            end else begin
              pc_s = pc_r;
            end
            state_s = S_FETCH;
          end
          OP_HALT:                  state_s = S_HALT;
          default: begin
            // Undefined opcodes behave as NOP but leave a sticky trace.
            illegal_s = 1'b1;
            state_s   = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        state_s = S_WRITE;
      end
      S_WRITE: begin
        if (opcode_s == OP_ALU) begin
          zero_s = (Resultado == 8'd0);
        end else begin
          zero_s = zero_r;
        end
        state_s = S_FETCH;
      end
      S_MEM: begin
        if (MemRdy) begin
          state_s = S_FETCH;
        end else begin
          wait_cnt_s = wait_cnt_r + 8'd1;
          if (wait_cnt_s == TIMEOUT_C) begin
            buserr_s = 1'b1;
            state_s  = S_FETCH;
          end else begin
            state_s  = S_MEM;
          end
        end
      end
      S_HALT: begin
        state_s = S_HALT;
      end
      default: begin
        state_s = S_FETCH;
      end
    endcase
  end

  // State, PC, IR, wait counter and sticky flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_FETCH;
      pc_r       <= RESET_PC;
      ir_r       <= 16'h0000;
      wait_cnt_r <= 8'd0;
      zero_r     <= 1'b0;
      buserr_r   <= 1'b0;
      illegal_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      ir_r       <= ir_s;
      wait_cnt_r <= wait_cnt_s;
      zero_r     <= zero_s;
      buserr_r   <= buserr_s;
      illegal_r  <= illegal_s;
    end
  end

  // Strobes and selects are registered from the next state so they are glitch-free
  // and drop at the same edge that leaves MEM or applies reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      regwr_wr_r <= 1'b0;
      memrd_r    <= 1'b0;
      memwr_r    <= 1'b0;
      halted_r   <= 1'b0;
      sel_r      <= 3'd0;
      alu_op_r   <= 3'd0;
    end else begin
      regwr_wr_r <= (state_s == S_WRITE);
      memrd_r    <= (state_s == S_MEM) && (opcode_s == OP_LOAD);
      memwr_r    <= (state_s == S_MEM) && (opcode_s == OP_STORE);
      halted_r   <= (state_s == S_HALT);
      sel_r      <= (state_s == S_WRITE) ? sel_for_op(opcode_s) : 3'd0;
      alu_op_r   <= ((state_s == S_EXEC) || (state_s == S_WRITE)) && (opcode_s == OP_ALU)
                    ? ir_r[2:0] : 3'd0;
    end
  end

endmodule

// File: tb/tb_unidad_control.sv
// Self-checking bench for unidad_control: directed scenarios plus a random
// instruction stream checked against an instruction-level reference model.
module tb_unidad_control;
  localparam int T = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] Instruccion;
  logic [7:0]  Resultado = 8'h00;
  logic        MemRdy = 1'b0;
  logic [7:0]  PC, Direccion;
  logic [2:0]  SEL, NUM, AddrX, AddrY, ALU_OP;
  logic        RegWr, MemRd, MemWr, Zero, Halted, BusErr, Illegal;

  logic [15:0] prog [0:255];
  assign Instruccion = prog[PC];

  unidad_control #(.MEM_TIMEOUT(T), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .Instruccion(Instruccion), .Resultado(Resultado),
    .MemRdy(MemRdy), .PC(PC), .SEL(SEL), .NUM(NUM), .Direccion(Direccion),
    .AddrX(AddrX), .AddrY(AddrY), .ALU_OP(ALU_OP), .RegWr(RegWr), .MemRd(MemRd),
    .MemWr(MemWr), .Zero(Zero), .Halted(Halted), .BusErr(BusErr), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Instruction-level reference model state
  logic [7:0] m_pc;
  logic       m_zero, m_buserr, m_illegal;
  // Expectations for the instruction being issued
  int         exp_n, exp_wr, exp_rd, exp_wm;
  logic [2:0] exp_sel, exp_aluop;
  logic [7:0] exp_fetch;
  // Observations collected over one instruction
  logic [7:0] o_pc_fetch, o_pc_decode, o_pc_next, o_dir;
  logic [2:0] o_sel, o_addrx, o_aluop;
  int         o_wr_cnt, o_wr_cyc, o_rd, o_wm, o_bad;
  logic       o_zero, o_buserr, o_illegal;

  task automatic model_reset();
    m_pc = 8'h00; m_zero = 1'b0; m_buserr = 1'b0; m_illegal = 1'b0;
  endtask

  // Architectural effect and cycle budget of one instruction.
  task automatic predict(input logic [15:0] ins, input int delay, input logic [7:0] res);
    logic [3:0] op;
    logic [7:0] nxt;
    int k;
    op = ins[15:12];
    nxt = m_pc + 8'd1;
    exp_n = 2; exp_wr = 0; exp_rd = 0; exp_wm = 0; exp_sel = 3'd0; exp_aluop = 3'd0;
    case (op)
      4'h1, 4'h6: begin
        k = (delay < T) ? delay + 1 : T;
        exp_n = 2 + k;
        if (op == 4'h1) exp_rd = k; else exp_wm = k;
        if (delay < T) begin
          if (op == 4'h1) exp_wr = 1;
        end else begin
          m_buserr = 1'b1;
        end
      end
      4'h2, 4'h3, 4'h4: begin
        exp_n = 3; exp_wr = 1; exp_sel = op[2:0] - 3'd1;
      end
      4'h5: begin
        exp_n = 4; exp_wr = 1; exp_sel = 3'd4; exp_aluop = ins[2:0];
        m_zero = (res == 8'h00);
      end
      4'h7: nxt = ins[7:0];
      4'h8: if (m_zero) nxt = ins[7:0];
      4'h0, 4'hF: ;
      default: m_illegal = 1'b1;
    endcase
    m_pc = nxt;
  endtask

  // Place an instruction at the model PC, run its predicted cycle count and observe.
  task automatic issue(input logic [15:0] ins, input int delay, input logic [7:0] res);
    exp_fetch = m_pc;
    prog[m_pc] = ins;
    predict(ins, delay, res);
    o_wr_cnt = 0; o_wr_cyc = -1; o_rd = 0; o_wm = 0; o_bad = 0;
    o_sel = 3'd0; o_addrx = 3'd0; o_dir = 8'h00; o_aluop = 3'd0;
    Resultado = res;
    for (int c = 0; c < exp_n; c++) begin
      MemRdy = (c == 2 + delay);
      #1;
      if (c == 0) o_pc_fetch = PC;
      if (c == 1) o_pc_decode = PC;
      if (c == 2) o_aluop = ALU_OP;
      if (RegWr) begin
        o_wr_cnt++; o_wr_cyc = c; o_sel = SEL; o_addrx = AddrX; o_dir = Direccion;
      end else if (SEL != 3'd0) begin
        o_bad++;
      end
      if (MemRd) o_rd++;
      if (MemWr) o_wm++;
      if ((MemRd && MemWr) || (RegWr && MemWr)) o_bad++;
      @(posedge clk);
      @(negedge clk);
    end
    MemRdy = 1'b0;
    #1;
    o_pc_next = PC; o_zero = Zero; o_buserr = BusErr; o_illegal = Illegal;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; MemRdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++; if (PC !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h want 00", PC); end
    vectors++; if ({RegWr, MemRd, MemWr} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b want 000", {RegWr, MemRd, MemWr}); end
    vectors++; if (SEL !== 3'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", SEL); end
    vectors++; if ({Zero, BusErr, Illegal, Halted} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {Zero, BusErr, Illegal, Halted}); end
    vectors++; if (Direccion !== 8'h00) begin errors++; $display("FAIL reset_ir: got %h want 00", Direccion); end
  endtask

  task automatic test_lda();
    do_reset();
    issue(16'h245A, 0, 8'h00);
    vectors++; if (o_pc_decode !== 8'h01) begin errors++; $display("FAIL lda_pc_inc: got %h want 01", o_pc_decode); end
    vectors++; if (o_wr_cnt !== 1 || o_wr_cyc !== 2) begin errors++; $display("FAIL lda_regwr: got cnt %0d cyc %0d want 1 2", o_wr_cnt, o_wr_cyc); end
    vectors++; if (o_sel !== 3'd1) begin errors++; $display("FAIL lda_sel: got %0d want 1", o_sel); end
    vectors++; if (o_addrx !== 3'd2 || o_dir !== 8'h5A) begin errors++; $display("FAIL lda_fields: got %0d %h want 2 5a", o_addrx, o_dir); end
    vectors++; if (o_pc_next !== 8'h01) begin errors++; $display("FAIL lda_next_pc: got %h want 01", o_pc_next); end
  endtask

  task automatic test_load_wait();
    do_reset();
    issue(16'h1220, 3, 8'h00);
    vectors++; if (o_rd !== 4) begin errors++; $display("FAIL load_memrd_len: got %0d want 4", o_rd); end
    vectors++; if (o_wr_cnt !== 1 || o_wr_cyc !== 5) begin errors++; $display("FAIL load_regwr: got cnt %0d cyc %0d want 1 5", o_wr_cnt, o_wr_cyc); end
    vectors++; if (o_sel !== 3'd0 || o_addrx !== 3'd1 || o_dir !== 8'h20) begin errors++; $display("FAIL load_fields: got %0d %0d %h want 0 1 20", o_sel, o_addrx, o_dir); end
    vectors++; if (o_buserr !== 1'b0) begin errors++; $display("FAIL load_buserr: got %b want 0", o_buserr); end
    // acknowledge on the last allowed cycle wins over the timeout
    issue(16'h1420, T - 1, 8'h00);
    vectors++; if (o_rd !== T || o_wr_cnt !== 1) begin errors++; $display("FAIL load_late_ack: got rd %0d wr %0d want %0d 1", o_rd, o_wr_cnt, T); end
    vectors++; if (o_buserr !== 1'b0) begin errors++; $display("FAIL load_late_buserr: got %b want 0", o_buserr); end
  endtask

  task automatic test_store_timeout();
    do_reset();
    issue(16'h6030, 1000, 8'h00);
    vectors++; if (o_wm !== T) begin errors++; $display("FAIL store_memwr_len: got %0d want %0d", o_wm, T); end
    vectors++; if (o_wr_cnt !== 0) begin errors++; $display("FAIL store_regwr: got %0d want 0", o_wr_cnt); end
    vectors++; if (o_buserr !== 1'b1 || o_pc_next !== 8'h01) begin errors++; $display("FAIL store_timeout: got buserr %b pc %h want 1 01", o_buserr, o_pc_next); end
    issue(16'h0000, 0, 8'h00);
    vectors++; if (o_buserr !== 1'b1 || o_pc_next !== 8'h02) begin errors++; $display("FAIL store_sticky: got buserr %b pc %h want 1 02", o_buserr, o_pc_next); end
  endtask

  task automatic test_alu_jz();
    do_reset();
    issue(16'h5213, 0, 8'h00);
    vectors++; if (o_aluop !== 3'd3 || o_sel !== 3'd4 || o_wr_cyc !== 3) begin errors++; $display("FAIL alu_write: got op %0d sel %0d cyc %0d want 3 4 3", o_aluop, o_sel, o_wr_cyc); end
    vectors++; if (o_zero !== 1'b1) begin errors++; $display("FAIL alu_zero_set: got %b want 1", o_zero); end
    issue(16'h8040, 0, 8'h00);
    vectors++; if (o_pc_next !== 8'h40) begin errors++; $display("FAIL jz_taken: got %h want 40", o_pc_next); end
    issue(16'h5215, 0, 8'h01);
    vectors++; if (o_zero !== 1'b0) begin errors++; $display("FAIL alu_zero_clr: got %b want 0", o_zero); end
    issue(16'h8040, 0, 8'h00);
    vectors++; if (o_pc_next !== 8'h42) begin errors++; $display("FAIL jz_fallthru: got %h want 42", o_pc_next); end
  endtask

  task automatic test_wrap_illegal();
    do_reset();
    issue(16'h70FF, 0, 8'h00);
    vectors++; if (o_pc_next !== 8'hFF) begin errors++; $display("FAIL jmp_ff: got %h want ff", o_pc_next); end
    issue(16'h0000, 0, 8'h00);
    vectors++; if (o_pc_next !== 8'h00 || o_illegal !== 1'b0) begin errors++; $display("FAIL pc_wrap: got %h ill %b want 00 0", o_pc_next, o_illegal); end
    issue(16'hB123, 0, 8'h00);
    vectors++; if (o_illegal !== 1'b1 || o_pc_next !== 8'h01 || o_wr_cnt !== 0) begin errors++; $display("FAIL illegal_op: got ill %b pc %h wr %0d want 1 01 0", o_illegal, o_pc_next, o_wr_cnt); end
  endtask

  task automatic test_halt();
    int halted_cnt, bad_pc, bad_strobe;
    halted_cnt = 0; bad_pc = 0; bad_strobe = 0;
    do_reset();
    prog[0] = 16'hF000;
    for (int c = 0; c < 22; c++) begin
      MemRdy = 1'($urandom_range(0, 1));
      #1;
      if (c >= 2) begin
        if (Halted) halted_cnt++;
        if (PC !== 8'h01) bad_pc++;
        if (RegWr || MemRd || MemWr) bad_strobe++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    MemRdy = 1'b0;
    vectors++; if (halted_cnt !== 20) begin errors++; $display("FAIL halt_flag: got %0d want 20", halted_cnt); end
    vectors++; if (bad_pc !== 0 || bad_strobe !== 0) begin errors++; $display("FAIL halt_frozen: got pc_bad %0d strobe_bad %0d want 0 0", bad_pc, bad_strobe); end
    prog[0] = 16'h0000;
    do_reset();
    #1;
    vectors++; if (Halted !== 1'b0 || PC !== 8'h00) begin errors++; $display("FAIL halt_exit: got %b %h want 0 00", Halted, PC); end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    issue(16'hC000, 0, 8'h00);
    issue(16'h5000, 0, 8'h00);
    vectors++; if (o_illegal !== 1'b1 || o_zero !== 1'b1) begin errors++; $display("FAIL pre_reset_flags: got %b %b want 1 1", o_illegal, o_zero); end
    prog[2] = 16'h1320;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    #1;
    vectors++; if (MemRd !== 1'b1) begin errors++; $display("FAIL mid_mem_rd: got %b want 1", MemRd); end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    #1;
    vectors++; if (MemRd !== 1'b0 || RegWr !== 1'b0 || PC !== 8'h00) begin errors++; $display("FAIL mid_mem_reset: got rd %b wr %b pc %h want 0 0 00", MemRd, RegWr, PC); end
    vectors++; if ({Illegal, Zero, BusErr} !== 3'b000) begin errors++; $display("FAIL mid_mem_flags: got %b want 000", {Illegal, Zero, BusErr}); end
    reset = 1'b0;
    model_reset();
    issue(16'h2177, 0, 8'h00);
    vectors++; if (o_pc_fetch !== 8'h00 || o_wr_cnt !== 1 || o_dir !== 8'h77) begin errors++; $display("FAIL restart_fetch: got pc %h wr %0d dir %h want 00 1 77", o_pc_fetch, o_wr_cnt, o_dir); end
  endtask

  task automatic test_random();
    logic [15:0] ins;
    int delay;
    logic [7:0] res;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      ins = {4'($urandom_range(0, 14)), 12'($urandom)};
      delay = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
      res = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      issue(ins, delay, res);
      vectors++; if (o_pc_fetch !== exp_fetch || o_pc_next !== m_pc) begin errors++; $display("FAIL rnd_pc ins=%h: got %h->%h want %h->%h", ins, o_pc_fetch, o_pc_next, exp_fetch, m_pc); end
      vectors++; if (o_wr_cnt !== exp_wr) begin errors++; $display("FAIL rnd_regwr ins=%h: got %0d want %0d", ins, o_wr_cnt, exp_wr); end
      if (exp_wr == 1) begin
        vectors++; if (o_wr_cyc !== exp_n - 1 || o_sel !== exp_sel) begin errors++; $display("FAIL rnd_write ins=%h: got cyc %0d sel %0d want %0d %0d", ins, o_wr_cyc, o_sel, exp_n - 1, exp_sel); end
        vectors++; if (o_addrx !== ins[11:9] || o_dir !== ins[7:0]) begin errors++; $display("FAIL rnd_fields ins=%h: got %0d %h want %0d %h", ins, o_addrx, o_dir, ins[11:9], ins[7:0]); end
      end
      vectors++; if (o_rd !== exp_rd || o_wm !== exp_wm) begin errors++; $display("FAIL rnd_mem ins=%h: got rd %0d wr %0d want %0d %0d", ins, o_rd, o_wm, exp_rd, exp_wm); end
      if (exp_n >= 3) begin
        vectors++; if (o_aluop !== exp_aluop) begin errors++; $display("FAIL rnd_aluop ins=%h: got %0d want %0d", ins, o_aluop, exp_aluop); end
      end
      vectors++; if ({o_zero, o_buserr, o_illegal} !== {m_zero, m_buserr, m_illegal}) begin errors++; $display("FAIL rnd_flags ins=%h: got %b want %b", ins, {o_zero, o_buserr, o_illegal}, {m_zero, m_buserr, m_illegal}); end
      vectors++; if (o_bad !== 0) begin errors++; $display("FAIL rnd_exclusive ins=%h: got %0d want 0", ins, o_bad); end
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) prog[a] = 16'h0000;
    model_reset();
    test_reset();
    test_lda();
    test_load_wait();
    test_store_timeout();
    test_alu_jz();
    test_wrap_illegal();
    test_halt();
    test_reset_mid_mem();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
